sync_fifo_buffer: RTL and testbench

Parametrised synchronous FIFO that supersedes the bare pointer-addressed memory array. Write/read pointers, occupancy counter, status flags and error pulses are held internally, so the producer and consumer only drive request strobes. It sits between a data producer and a consumer within a single clock domain. Read data is registered and qualified by a valid strobe.

---
 rtl/sync_fifo_buffer.sv | 97 +++++++++
 tb/tb_sync_fifo_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_buffer.sv
// sync_fifo_buffer: single-clock FIFO with registered read data, occupancy
// counter, status flags and one-cycle overflow/underflow pulses.
module sync_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_clr,
    input  logic                  fifo_we,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  rd_ok;
    logic                  wr_ok;

    // Status flags and request acceptance, decoded from the registered count
    always_comb begin
        fifo_full    = (fifo_count == DEPTH_CNT);
        fifo_empty   = (fifo_count == '0);
        almost_full  = (fifo_count >= AF_CNT);
        almost_empty = (fifo_count <= AE_CNT);
        rd_ok        = fifo_rd && !fifo_empty;
        // A full FIFO still takes a write when a read frees the slot this cycle
        wr_ok        = fifo_we && (!fifo_full || rd_ok);
    end

    // Storage array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (!fifo_clr && wr_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Pointers, occupancy, registered read data and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (fifo_clr) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            // Read samples the array before this edge's write lands (read-before-write)
            if (rd_ok) begin
                data_out <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr     <= rptr + ONE;
            end
            data_valid <= rd_ok;
            case ({wr_ok, rd_ok})
                2'b10:   fifo_count <= fifo_count + ONE;
                2'b01:   fifo_count <= fifo_count - ONE;
                default: fifo_count <= fifo_count;
            endcase
            overflow  <= fifo_we && !wr_ok;
            underflow <= fifo_rd && !rd_ok;
        end
    end

    // The wrap bits make the pointer distance equal the occupancy at all times
    assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count == (wptr - rptr));

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Testbench for sync_fifo_buffer: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_sync_fifo_buffer;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_clr = 1'b0;
    logic          fifo_we = 1'b0;
    logic          fifo_rd = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          underflow;

    sync_fifo_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_clr    (fifo_clr),
        .fifo_we     (fifo_we),
        .data_in     (data_in),
        .fifo_rd     (fifo_rd),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Reference model: stored words in a queue plus the registered outputs
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;

    typedef struct {
        logic          clr;
        logic          we;
        logic          rd;
        logic [DW-1:0] din;
        logic [AW:0]   e_cnt;
        logic          e_valid;
        logic [DW-1:0] e_dout;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Apply one clock of requests to the model, using its pre-edge occupancy
    task automatic model_step(input logic clr, input logic we, input logic rd, input logic [DW-1:0] din);
        bit rd_acc;
        bit wr_acc;
        if (clr) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            rd_acc = rd && (mq.size() != 0);
            wr_acc = we && ((mq.size() < DEPTH) || rd_acc);
            if (rd_acc) m_dout = mq.pop_front();
            m_valid = rd_acc;
            if (wr_acc) mq.push_back(din);
            m_ovf = we && !wr_acc;
            m_unf = rd && !rd_acc;
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = mq.size();
        chk($sformatf("%s.count", tag), 64'(fifo_count), 64'(n));
        chk($sformatf("%s.valid", tag), 64'(data_valid), 64'(m_valid));
        chk($sformatf("%s.dout", tag), 64'(data_out), 64'(m_dout));
        chk($sformatf("%s.full", tag), 64'(fifo_full), 64'(n == DEPTH));
        chk($sformatf("%s.empty", tag), 64'(fifo_empty), 64'(n == 0));
        chk($sformatf("%s.afull", tag), 64'(almost_full), 64'(n >= AF));
        chk($sformatf("%s.aempty", tag), 64'(almost_empty), 64'(n <= AE));
        chk($sformatf("%s.ovf", tag), 64'(overflow), 64'(m_ovf));
        chk($sformatf("%s.unf", tag), 64'(underflow), 64'(m_unf));
    endtask

    task automatic step(input string tag, input logic clr, input logic we, input logic rd, input logic [DW-1:0] din);
        fifo_clr = clr;
        fifo_we  = we;
        fifo_rd  = rd;
        data_in  = din;
        model_step(clr, we, rd, din);
        @(posedge clk);
        #1;
        fifo_clr = 1'b0;
        fifo_we  = 1'b0;
        fifo_rd  = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h11, 5'd1, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h22, 5'd2, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd1, 1'b1, 32'h11, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h33, 5'd1, 1'b1, 32'h22, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0, 1'b1, 32'h33, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0, 1'b0, 32'h33, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h44, 5'd1, 1'b0, 32'h33, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h55, 5'd0, 1'b0, 32'h33, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0, 1'b0, 32'h33, 1'b0, 1'b1};

        // Reset
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("rst_held");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst_rel");
        chk("rst.dout_zero", 64'(data_out), 64'h0);
        chk("rst.empty", 64'(fifo_empty), 64'h1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].clr, tbl[i].we, tbl[i].rd, tbl[i].din);
            chk($sformatf("tbl%0d.e_cnt", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.e_valid", i), 64'(data_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.e_dout", i), 64'(data_out), 64'(tbl[i].e_dout));
            chk($sformatf("tbl%0d.e_ovf", i), 64'(overflow), 64'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d.e_unf", i), 64'(underflow), 64'(tbl[i].e_unf));
        end

        // Fill to full, overflow, full with simultaneous read/write
        for (int i = 0; i < 16; i++) begin
            step($sformatf("fill%0d", i), 1'b0, 1'b1, 1'b0, 32'(i));
            chk($sformatf("fill%0d.af", i), 64'(almost_full), 64'(i >= 13));
        end
        chk("fill.full", 64'(fifo_full), 64'h1);
        step("ovf", 1'b0, 1'b1, 1'b0, 32'hDEAD);
        chk("ovf.pulse", 64'(overflow), 64'h1);
        chk("ovf.count", 64'(fifo_count), 64'd16);
        step("ovf_after", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("ovf.one_cycle", 64'(overflow), 64'h0);
        step("full_wr_rd", 1'b0, 1'b1, 1'b1, 32'h100);
        chk("full_wr_rd.count", 64'(fifo_count), 64'd16);
        chk("full_wr_rd.no_ovf", 64'(overflow), 64'h0);
        chk("full_wr_rd.dout", 64'(data_out), 64'h0);

        // Drain: words 1..15 then the word written alongside the read at full
        for (int i = 0; i < 16; i++) begin
            step($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b1, 32'h0);
            chk($sformatf("drain%0d.word", i), 64'(data_out), (i < 15) ? 64'(i + 1) : 64'h100);
            chk($sformatf("drain%0d.v", i), 64'(data_valid), 64'h1);
        end
        step("unf", 1'b0, 1'b0, 1'b1, 32'h0);
        chk("unf.pulse", 64'(underflow), 64'h1);
        chk("unf.empty", 64'(fifo_empty), 64'h1);

        // Empty with simultaneous read/write, then wrap-around traffic
        for (int i = 0; i < 3; i++) begin
            step($sformatf("wr_rd%0d", i), 1'b0, 1'b1, 1'b1, 32'h700 + 32'(i));
        end
        step("wr_rd_drain", 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step($sformatf("wrap%0d", i), 1'b0, 1'b1, 1'b0, 32'hAA55AA55 ^ 32'(i));
            else            step($sformatf("wrap%0d", i), 1'b0, 1'b0, 1'b1, 32'h0);
            chk($sformatf("wrap%0d.le1", i), 64'(fifo_count <= 5'd1), 64'h1);
            if (i % 2 == 1) chk($sformatf("wrap%0d.word", i), 64'(data_out), 64'(32'hAA55AA55 ^ 32'(i - 1)));
        end

        // Flush at count 9 together with a write
        for (int i = 0; i < 9; i++) step($sformatf("pre_clr%0d", i), 1'b0, 1'b1, 1'b0, 32'h900 + 32'(i));
        step("clr", 1'b1, 1'b1, 1'b0, 32'h1234);
        chk("clr.count", 64'(fifo_count), 64'h0);
        chk("clr.empty", 64'(fifo_empty), 64'h1);
        chk("clr.no_ovf", 64'(overflow), 64'h0);
        step("clr_wr", 1'b0, 1'b1, 1'b0, 32'h55AA55AA);
        step("clr_rd", 1'b0, 1'b0, 1'b1, 32'h0);
        chk("clr.first_word", 64'(data_out), 64'h55AA55AA);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), $urandom);
        end

        // Asynchronous reset between edges at count 5
        step("pre_ar_clr", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step($sformatf("pre_ar%0d", i), 1'b0, 1'b1, 1'b0, 32'hC00 + 32'(i));
        chk("pre_ar.count", 64'(fifo_count), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("async_rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_ar", 1'b0, 1'b0, 1'b1, 32'h0);
        chk("post_ar.unf", 64'(underflow), 64'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
